// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer: owns the raster position and muxes NUM_SRC pattern
// sources onto one registered RGB output. The displayed source changes only at
// frame boundaries, either on a manual request or after HOLD_FRAMES frames.
// The incoming source gets a one-cycle restart pulse so that its pixel counter
// is aligned to the frame.
module vga_pattern_sequencer #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACTIVE    = 480,
    parameter int NUM_SRC     = 3,
    parameter int SEL_W       = 2,
    parameter int HOLD_FRAMES = 60
) (
    input  logic                   vga_clk,
    input  logic                   arst_n,
    input  logic                   next_req,
    input  logic                   auto_en,
    input  logic [NUM_SRC*24-1:0]  src_rgb,
    output logic [NUM_SRC-1:0]     src_restart,
    output logic [SEL_W-1:0]       src_sel,
    output logic [7:0]             red,
    output logic [7:0]             green,
    output logic [7:0]             blue,
    output logic                   de,
    output logic                   frame_start
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int FW = $clog2(HOLD_FRAMES + 1);

    typedef enum logic {
        SHOW = 1'b0,   // displaying a source, no advance requested
        PEND = 1'b1    // advance requested, taken at the next frame end
    } state_t;

    logic [HW-1:0]      h_q, h_d;
    logic [VW-1:0]      v_q, v_d;
    state_t             state_q, state_d;
    logic [FW-1:0]      frame_q, frame_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_SRC-1:0] restart_q, restart_d;
    logic               req_q, req_d;
    logic [23:0]        rgb_q, rgb_d;
    logic               de_q, de_d;

    logic               h_end, v_end, last, decide, active;
    logic               req_rise, auto_expire, switching;
    logic [SEL_W-1:0]   next_sel;
    logic [23:0]        pix;

    // Raster decode, request edge detect and the selected source pixel.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        pix         = '0;
        h_end       = (h_q == HW'(H_TOTAL - 1));
        v_end       = (v_q == VW'(V_TOTAL - 1));
        last        = h_end && v_end;
        decide      = (h_q == HW'(H_TOTAL - 2)) && v_end;
        active      = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
        req_rise    = next_req && !req_q;
        auto_expire = auto_en && (state_q == SHOW) && (frame_q == FW'(HOLD_FRAMES - 1));
        next_sel    = (sel_q == SEL_W'(NUM_SRC - 1)) ? '0 : sel_q + 1'b1;
        // The restart pulse is only ever high in the LAST cycle of a switching frame.
        switching   = |restart_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel_q == SEL_W'(k)) pix = src_rgb[24*k +: 24];
        end
    end

    // Next-state logic: raster counters, advance FSM, frame hold counter, output pipe.
    always_comb begin
        h_d       = h_end ? '0 : h_q + 1'b1;
        v_d       = v_q;
        state_d   = state_q;
        frame_d   = frame_q;
        sel_d     = sel_q;
        restart_d = '0;
        req_d     = next_req;
        de_d      = active;
        rgb_d     = active ? pix : 24'h0;

        if (h_end) v_d = v_end ? '0 : v_q + 1'b1;

        // Decide one cycle early so the restart pulse lands exactly on LAST.
        // A request arriving on LAST itself misses this decision and waits a frame.
        if (decide && (state_q == PEND || req_rise || auto_expire))
            restart_d = NUM_SRC'(1) << next_sel;

        case (state_q)
            SHOW:    if (req_rise) state_d = PEND;
            PEND:    state_d = PEND;   // further requests coalesce here
            default: state_d = SHOW;
        endcase

        if (last) begin
            if (switching) begin
                sel_d   = next_sel;
                frame_d = '0;
                state_d = req_rise ? PEND : SHOW;
            end else if (auto_en && state_q == SHOW && frame_q < FW'(HOLD_FRAMES - 1)) begin
                frame_d = frame_q + 1'b1;
            end
        end

        if (!auto_en) frame_d = '0;
    end

    // State registers, all cleared immediately by the asynchronous reset.
    always_ff @(posedge vga_clk or negedge arst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!arst_n) begin
            h_q       <= '0;
            v_q       <= '0;
            state_q   <= SHOW;
            frame_q   <= '0;
            sel_q     <= '0;
            restart_q <= '0;
            req_q     <= 1'b0;
            rgb_q     <= '0;
            de_q      <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            state_q   <= state_d;
            frame_q   <= frame_d;
            sel_q     <= sel_d;
            restart_q <= restart_d;
            req_q     <= req_d;
            rgb_q     <= rgb_d;
            de_q      <= de_d;
        end
    end

    assign src_restart = restart_q;
    assign src_sel     = sel_q;
    assign red         = rgb_q[23:16];
    assign green       = rgb_q[15:8];
    assign blue        = rgb_q[7:0];
    assign de          = de_q;
    // Gated by reset so the raster origin held during reset does not read as a frame start.
    assign frame_start = arst_n && (h_q == '0) && (v_q == '0);

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Bench for vga_pattern_sequencer on a reduced 10x5 raster (6x3 active, 50
// cycles per frame), HOLD_FRAMES=2, three sources. Stimulus pushes expected
// source switches (cycle, new index) into a scoreboard; the monitor pops them
// and checks src_sel, src_restart, de, RGB and frame_start every cycle.
module tb_vga_pattern_sequencer;

    localparam int HT = 10, HA = 6, VT = 5, VA = 3;
    localparam int FRAME = HT * VT;

    logic        vga_clk = 1'b0;
    logic        arst_n  = 1'b0;
    logic        next_req = 1'b0;
    logic        auto_en  = 1'b0;
    logic [71:0] src_rgb  = {24'h333333, 24'h222222, 24'h111111};
    logic [2:0]  src_restart;
    logic [1:0]  src_sel;
    logic [7:0]  red, green, blue;
    logic        de, frame_start;

    typedef struct {
        int         cycle;
        logic [1:0] sel;
    } ev_t;

    ev_t  sb[$];
    int   cyc;
    int   exp_sel = 0;
    int   compared = 0;
    int   mismatched = 0;

    vga_pattern_sequencer #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA),
        .NUM_SRC(3), .SEL_W(2), .HOLD_FRAMES(2)
    ) dut (
        .vga_clk(vga_clk), .arst_n(arst_n), .next_req(next_req), .auto_en(auto_en),
        .src_rgb(src_rgb), .src_restart(src_restart), .src_sel(src_sel),
        .red(red), .green(green), .blue(blue), .de(de), .frame_start(frame_start)
    );

    always #5 vga_clk = ~vga_clk;

    // Cycle index since reset release; cycle 0 is the raster origin.
    always @(posedge vga_clk or negedge arst_n) begin
        if (!arst_n) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int k);
        while (cyc != k) @(negedge vga_clk);
    endtask

    task automatic pulse_req(input int k);
        wait_cyc(k);
        next_req = 1'b1;
        @(negedge vga_clk);
        next_req = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rgb"},     {8'h0, red, green, blue}, 32'h0);
        check({tag, "_de"},      {31'h0, de}, 32'h0);
        check({tag, "_fstart"},  {31'h0, frame_start}, 32'h0);
        check({tag, "_sel"},     {30'h0, src_sel}, 32'h0);
        check({tag, "_restart"}, {29'h0, src_restart}, 32'h0);
    endtask

    task automatic do_reset(input logic auto);
        arst_n   = 1'b0;
        next_req = 1'b0;
        auto_en  = auto;
        exp_sel  = 0;
        repeat (2) @(negedge vga_clk);
        check_zero_outputs("reset");
        check("sb_empty_at_reset", sb.size(), 0);
        arst_n = 1'b1;
    endtask

    // Monitor: compares every cycle against the raster model and scoreboard.
    initial begin
        forever begin
            @(negedge vga_clk);
            #1;
            if (arst_n) begin
                int         p;
                logic       de_exp;
                logic [2:0] rst_exp;
                logic [23:0] rgb_exp;
                p       = cyc - 1;
                de_exp  = (cyc > 0) && ((p % HT) < HA) && (((p / HT) % VT) < VA);
                rst_exp = '0;
                if (sb.size() > 0 && cyc == sb[0].cycle - 1) rst_exp = 3'b001 << sb[0].sel;
                if (sb.size() > 0 && cyc == sb[0].cycle) begin
                    exp_sel = int'(sb[0].sel);
                    void'(sb.pop_front());
                end
                rgb_exp = de_exp ? 24'(32'h111111 * (exp_sel + 1)) : 24'h0;
                check("src_sel",     {30'h0, src_sel}, 32'(exp_sel));
                check("src_restart", {29'h0, src_restart}, {29'h0, rst_exp});
                check("de",          {31'h0, de}, {31'h0, de_exp});
                check("rgb",         {8'h0, red, green, blue}, {8'h0, rgb_exp});
                check("frame_start", {31'h0, frame_start}, {31'h0, (cyc % FRAME) == 0});
            end
        end
    end

    // Stimulus: directed scenarios with hand-computed switch cycles.
    initial begin
        // Free run two frames, no switching.
        do_reset(1'b0);
        wait_cyc(2 * FRAME);

        // Manual request mid-frame 0 -> switch at 50; request on LAST (149) -> switch at 200.
        do_reset(1'b0);
        sb.push_back('{cycle: 50,  sel: 2'd1});
        sb.push_back('{cycle: 200, sel: 2'd2});
        pulse_req(20);
        pulse_req(149);
        wait_cyc(260);

        // Auto mode every 2 frames, including the wrap 2 -> 0.
        do_reset(1'b1);
        sb.push_back('{cycle: 100, sel: 2'd1});
        sb.push_back('{cycle: 200, sel: 2'd2});
        sb.push_back('{cycle: 300, sel: 2'd0});
        wait_cyc(320);

        // Three requests plus auto expiry at the same frame end -> one advance only.
        do_reset(1'b1);
        sb.push_back('{cycle: 100, sel: 2'd1});
        sb.push_back('{cycle: 200, sel: 2'd2});
        pulse_req(55);
        pulse_req(60);
        pulse_req(70);
        wait_cyc(210);

        // Reset while a request is pending: outputs clear at once, request is lost.
        do_reset(1'b0);
        pulse_req(10);
        wait_cyc(30);
        #2;
        arst_n = 1'b0;
        #1;
        check_zero_outputs("midframe_reset");
        do_reset(1'b0);
        wait_cyc(3 * FRAME);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
